// File: rtl/adc_capture_seq.sv
// -----------------------------------------------------------------------------
// adc_capture_seq
//
// Multi-channel ADC capture sequencer. Incoming samples are decimated by a
// power-of-two ratio (block average with arithmetic truncation) and written
// into a circular capture memory of depth 2^AW. A capture takes `pretrig`
// pre-trigger writes, waits for a trigger, then fills the rest of the ring
// so that the buffer holds exactly 2^AW samples around the trigger point.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   adc_data   in   NCH*DW  channel k at [(k+1)*DW-1 -: DW], signed
//   log_ratio  in   LRW     decimation exponent (0..10)
//   chan_mask  in   NCH     1 = channel enabled, disabled lanes write zero
//   mode       in   1       0 one-shot, 1 continuous re-arm
//   pretrig    in   AW      number of pre-trigger writes
//   arm        in   1       start a capture (honoured in IDLE/DONE only)
//   trig       in   1       trigger strobe (honoured in WAIT only)
//   abort      in   1       return to IDLE, highest priority
//   wr_en      out  1       capture memory write enable
//   wr_addr    out  AW      capture memory write address
//   wr_data    out  NCH*DW  capture memory write data
//   state      out  3       0 IDLE, 1 PRE, 2 WAIT, 3 POST, 4 DONE
//   trig_ptr   out  AW      address of the trigger sample
//   full       out  1       a complete capture is in memory
//   done       out  1       one-cycle pulse on capture completion
// -----------------------------------------------------------------------------
module adc_capture_seq #(
  parameter int NCH = 8,
  parameter int DW  = 16,
  parameter int AW  = 14,
  parameter int LRW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH*DW-1:0] adc_data,
  input  logic [LRW-1:0]    log_ratio,
  input  logic [NCH-1:0]    chan_mask,
  input  logic              mode,
  input  logic [AW-1:0]     pretrig,
  input  logic              arm,
  input  logic              trig,
  input  logic              abort,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [NCH*DW-1:0] wr_data,
  output logic [2:0]        state,
  output logic [AW-1:0]     trig_ptr,
  output logic              full,
  output logic              done
);

  // Ten guard bits cover the largest legal block of 2^10 samples.
  localparam int AccW = DW + 10;
  localparam int PhW  = 10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e state_q, state_d;

  // Capture configuration, frozen for the duration of a capture.
  logic [LRW-1:0] lr_q;
  logic [NCH-1:0] mask_q;
  logic           mode_q;
  logic [AW-1:0]  pretrig_q;

  // Decimator.
  logic [PhW-1:0]         phase_q;
  logic signed [AccW-1:0] acc_q   [NCH];
  logic signed [AccW-1:0] sum_c   [NCH];
  logic signed [AccW-1:0] shift_c [NCH];
  logic [NCH*DW-1:0]      dec_out;
  logic [PhW:0]           ratio;
  logic [PhW-1:0]         phase_end;
  logic                   phase_last;

  // Sequencer.
  logic              active, stb, arm_ok, clear_full;
  logic [AW-1:0]     ptr_q, wr_addr_q, trig_ptr_q, trig_ptr_d;
  logic [AW:0]       cnt_q, cnt_d, cnt_inc, post_need, post_base, post_inc;
  logic              wr_en_q, full_q, full_d, done_q, done_d;
  logic [NCH*DW-1:0] wr_data_q;

  // ---------------------------------------------------------------------------
  // Control qualifiers
  // ---------------------------------------------------------------------------
  assign active = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);

  // ratio is one bit wider than the phase counter so that 2^10 is representable;
  // the phase wraps at ratio-1.
  assign ratio      = {{PhW{1'b0}}, 1'b1} << lr_q;
  assign phase_end  = PhW'(ratio - 1'b1);
  assign phase_last = (phase_q == phase_end);

  // A strobe in the abort cycle is dropped so nothing is written on the way out.
  assign stb = active && phase_last && !abort;

  // DONE in continuous mode re-arms by itself after its single cycle.
  assign arm_ok = !abort &&
                  (((state_q == S_IDLE) && arm) ||
                   ((state_q == S_DONE) && (arm || mode_q)));

  // Continuous re-arm keeps the previous capture marked as complete.
  assign clear_full = !((state_q == S_DONE) && mode_q);

  // Number of writes in POST, trigger sample included; needs AW+1 bits when
  // pretrig is zero.
  assign post_need = {1'b1, {AW{1'b0}}} - {1'b0, pretrig_q};
  assign cnt_inc   = cnt_q + 1'b1;
  assign post_base = (state_q == S_POST) ? cnt_q : '0;
  assign post_inc  = post_base + 1'b1;

  // ---------------------------------------------------------------------------
  // Decimator datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    dec_out = '0;
    for (int k = 0; k < NCH; k++) begin
      sum_c[k]   = acc_q[k] + {{(AccW-DW){adc_data[k*DW+DW-1]}}, adc_data[k*DW +: DW]};
      shift_c[k] = sum_c[k] >>> lr_q;
      dec_out[k*DW +: DW] = mask_q[k] ? shift_c[k][DW-1:0] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the accumulators are a small flop array, not a RAM, so they are
    // reset with everything else; a real memory array would be left unreset.
    if (!rst_n) begin
      phase_q <= '0;
      for (int k = 0; k < NCH; k++) acc_q[k] <= '0;
    end else if (arm_ok) begin
      phase_q <= '0;
      for (int k = 0; k < NCH; k++) acc_q[k] <= '0;
    end else if (active) begin
      if (phase_last) begin
        phase_q <= '0;
        for (int k = 0; k < NCH; k++) acc_q[k] <= '0;
      end else begin
        phase_q <= phase_q + 1'b1;
        for (int k = 0; k < NCH; k++) acc_q[k] <= sum_c[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    trig_ptr_d = trig_ptr_q;
    full_d     = full_q;
    done_d     = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
    end else if (arm_ok) begin
      state_d = (pretrig == '0) ? S_WAIT : S_PRE;
      cnt_d   = '0;
      if (clear_full) full_d = 1'b0;
    end else begin
      case (state_q)
        S_PRE: begin
          // Triggers are deliberately not remembered here.
          if (stb) begin
            cnt_d = cnt_inc;
            if (cnt_inc == {1'b0, pretrig_q}) begin
              state_d = S_WAIT;
              cnt_d   = '0;
            end
          end
        end
        S_WAIT, S_POST: begin
          // A trigger in WAIT behaves like the first POST cycle, so a write
          // strobed in the trigger cycle itself becomes the trigger sample.
          if ((state_q == S_POST) || trig) begin
            state_d = S_POST;
            cnt_d   = post_base;
            if (stb) begin
              if (post_base == '0) trig_ptr_d = ptr_q;
              cnt_d = post_inc;
              if (post_inc == post_need) begin
                state_d = S_DONE;
                done_d  = 1'b1;
                full_d  = 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
    // so the order of statements in this block does not matter.
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      trig_ptr_q <= '0;
      full_q     <= 1'b0;
      done_q     <= 1'b0;
      lr_q       <= '0;
      mask_q     <= '0;
      mode_q     <= 1'b0;
      pretrig_q  <= '0;
      ptr_q      <= '0;
      wr_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      trig_ptr_q <= trig_ptr_d;
      full_q     <= full_d;
      done_q     <= done_d;
      wr_en_q    <= stb;
      if (stb) wr_data_q <= dec_out;

      if (arm_ok) begin
        lr_q      <= log_ratio;
        mask_q    <= chan_mask;
        mode_q    <= mode;
        pretrig_q <= pretrig;
        ptr_q     <= '0;
        wr_addr_q <= '0;
      end else begin
        // ptr_q is the address the next strobe will use; wr_addr trails it by
        // one cycle so it lines up with the registered write, and afterwards
        // shows the following address.
        if (stb) ptr_q <= ptr_q + 1'b1;
        wr_addr_q <= ptr_q;
      end
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign state    = state_q;
  assign trig_ptr = trig_ptr_q;
  assign full     = full_q;
  assign done     = done_q;

endmodule

// File: tb/tb_adc_capture_seq.sv
// -----------------------------------------------------------------------------
// tb_adc_capture_seq
//
// Self-checking bench for adc_capture_seq with a 16-entry capture ring.
// Each test task drives stimulus and pushes the writes it expects into a
// scoreboard queue; a monitor pops and compares every write the DUT makes.
// -----------------------------------------------------------------------------
module tb_adc_capture_seq;

  localparam int NCH = 8;
  localparam int DW  = 16;
  localparam int AW  = 4;
  localparam int LRW = 4;

  logic              clk;
  logic              rst_n;
  logic [NCH*DW-1:0] adc_data;
  logic [LRW-1:0]    log_ratio;
  logic [NCH-1:0]    chan_mask;
  logic              mode;
  logic [AW-1:0]     pretrig;
  logic              arm, trig, abort;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [NCH*DW-1:0] wr_data;
  logic [2:0]        state;
  logic [AW-1:0]     trig_ptr;
  logic              full, done;

  typedef struct {
    logic [AW-1:0]     addr;
    logic [NCH*DW-1:0] data;
  } wr_t;

  wr_t sb_q[$];
  wr_t mon_exp;
  int  errors = 0;
  int  checks = 0;

  adc_capture_seq #(.NCH(NCH), .DW(DW), .AW(AW), .LRW(LRW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .adc_data  (adc_data),
    .log_ratio (log_ratio),
    .chan_mask (chan_mask),
    .mode      (mode),
    .pretrig   (pretrig),
    .arm       (arm),
    .trig      (trig),
    .abort     (abort),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .state     (state),
    .trig_ptr  (trig_ptr),
    .full      (full),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: outputs are sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_en === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=%h while none was expected",
                 wr_addr, wr_data);
      end else begin
        mon_exp = sb_q.pop_front();
        if (wr_addr !== mon_exp.addr || wr_data !== mon_exp.data) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%h expected addr=%0d data=%h",
                   wr_addr, wr_data, mon_exp.addr, mon_exp.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Distinct nonzero value on every lane of every cycle.
  function automatic logic [NCH*DW-1:0] pat(input int c);
    logic [NCH*DW-1:0] v;
    for (int k = 0; k < NCH; k++) v[k*DW +: DW] = DW'(c * 16 + k + 1);
    return v;
  endfunction

  // ch0 cycles through 4,8,12,16; lane k holds the constant -k.
  function automatic logic [NCH*DW-1:0] dec_in(input int c);
    logic [NCH*DW-1:0] v;
    v[0 +: DW] = DW'(4 * (((c - 1) % 4) + 1));
    for (int k = 1; k < NCH; k++) v[k*DW +: DW] = DW'(-k);
    return v;
  endfunction

  function automatic logic [NCH*DW-1:0] dec_exp();
    logic [NCH*DW-1:0] v;
    v[0 +: DW] = DW'(10);
    for (int k = 1; k < NCH; k++) v[k*DW +: DW] = DW'(-k);
    return v;
  endfunction

  task automatic sb_empty(input string name);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_writes: got %0d writes outstanding expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic do_abort(input string name);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (state !== 3'd0 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL %s_abort: got state=%0d wr_en=%b expected state=0 wr_en=0", name, state, wr_en);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({state, wr_en, wr_addr, wr_data, trig_ptr, full, done} !== '0) begin
      errors++;
      $display("FAIL reset_values: got state=%0d wr_en=%b wr_addr=%0d trig_ptr=%0d full=%b done=%b expected all 0",
               state, wr_en, wr_addr, trig_ptr, full, done);
    end
    #4;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (state !== 3'd0 || wr_en !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle: got state=%0d wr_en=%b expected state=0 wr_en=0", state, wr_en);
      end
    end
  endtask

  task automatic test_basic();
    int done_cnt = 0;
    int done_at  = -1;
    log_ratio = 0; chan_mask = '1; mode = 1'b0; pretrig = 4;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    // Changes after arm must not affect the running capture.
    log_ratio = 3; pretrig = 7;
    checks++;
    if (state !== 3'd1 || full !== 1'b0 || wr_addr !== '0) begin
      errors++;
      $display("FAIL basic_arm: got state=%0d full=%b wr_addr=%0d expected 1 0 0", state, full, wr_addr);
    end
    for (int c = 1; c <= 26; c++) begin
      adc_data = pat(c);
      trig = (c == 10);
      if (c <= 21) sb_q.push_back('{addr: AW'(c - 1), data: pat(c)});
      tick();
      trig = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
      if (c == 3 || c == 4) begin
        checks++;
        if (state !== ((c == 3) ? 3'd1 : 3'd2)) begin
          errors++;
          $display("FAIL basic_pre_to_wait: cycle %0d got state=%0d expected %0d", c, state, (c == 3) ? 1 : 2);
        end
      end
    end
    checks++;
    if (done_cnt != 1 || done_at != 21) begin
      errors++;
      $display("FAIL basic_done: got %0d pulses last at cycle %0d expected 1 pulse at cycle 21", done_cnt, done_at);
    end
    checks++;
    if (state !== 3'd4 || full !== 1'b1 || trig_ptr !== AW'(9)) begin
      errors++;
      $display("FAIL basic_final: got state=%0d full=%b trig_ptr=%0d expected 4 1 9", state, full, trig_ptr);
    end
    sb_empty("basic");
    do_abort("basic");
  endtask

  task automatic test_decimation();
    log_ratio = 2; chan_mask = '1; mode = 1'b0; pretrig = 0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      adc_data = dec_in(c);
      if (c % 4 == 0) sb_q.push_back('{addr: AW'(c / 4 - 1), data: dec_exp()});
      tick();
      checks++;
      if (wr_en !== (c % 4 == 0)) begin
        errors++;
        $display("FAIL decim4_wr_en: cycle %0d got %b expected %b", c, wr_en, (c % 4 == 0));
      end
    end
    do_abort("decim4");

    log_ratio = 1;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      adc_data = '0;
      adc_data[0 +: DW] = (c % 2 == 1) ? DW'(-1) : DW'(-2);
      if (c % 2 == 0) begin
        wr_t e;
        e.addr = AW'(c / 2 - 1);
        e.data = '0;
        e.data[0 +: DW] = DW'(-2);
        sb_q.push_back(e);
      end
      tick();
    end
    do_abort("decim2");
    sb_empty("decim");
  endtask

  task automatic test_trig_in_pre();
    log_ratio = 0; chan_mask = '1; mode = 1'b0; pretrig = 4;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      adc_data = pat(c + 30);
      trig = (c == 2);
      sb_q.push_back('{addr: AW'(c - 1), data: pat(c + 30)});
      tick();
      trig = 1'b0;
      checks++;
      if (state === 3'd3 || done !== 1'b0) begin
        errors++;
        $display("FAIL pretrig_ignored: cycle %0d got state=%0d done=%b expected no POST, no done", c, state, done);
      end
    end
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL pretrig_wait: got state=%0d expected 2", state);
    end
    // The abort cycle carries a strobe that must not reach the write port.
    adc_data = pat(99);
    do_abort("pretrig");
    checks++;
    if (trig_ptr !== AW'(9)) begin
      errors++;
      $display("FAIL pretrig_trig_ptr: got %0d expected 9", trig_ptr);
    end
    sb_empty("pretrig");
  endtask

  task automatic test_continuous();
    log_ratio = 0; chan_mask = '1; mode = 1'b1; pretrig = 0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL cont_arm_wait: got state=%0d expected 2", state);
    end
    for (int c = 1; c <= 40; c++) begin
      adc_data = pat(c + 50);
      trig = (c == 3 || c == 25);
      if (c <= 18) sb_q.push_back('{addr: AW'(c - 1), data: pat(c + 50)});
      else if (c >= 20) sb_q.push_back('{addr: AW'(c - 20), data: pat(c + 50)});
      tick();
      trig = 1'b0;
      checks++;
      if (done !== (c == 18 || c == 40)) begin
        errors++;
        $display("FAIL cont_done: cycle %0d got %b expected %b", c, done, (c == 18 || c == 40));
      end
      if (c == 19) begin
        checks++;
        if (state !== 3'd2 || wr_addr !== '0 || full !== 1'b1) begin
          errors++;
          $display("FAIL cont_rearm: got state=%0d wr_addr=%0d full=%b expected 2 0 1", state, wr_addr, full);
        end
      end
    end
    checks++;
    if (state !== 3'd4 || full !== 1'b1 || trig_ptr !== AW'(5)) begin
      errors++;
      $display("FAIL cont_final: got state=%0d full=%b trig_ptr=%0d expected 4 1 5", state, full, trig_ptr);
    end
    do_abort("cont");
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL cont_full_kept: got %b expected 1", full);
    end
    sb_empty("cont");
  endtask

  task automatic test_mask();
    log_ratio = 0; chan_mask = 8'b0000_0001; mode = 1'b0; pretrig = 0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chan_mask = '1;
    checks++;
    if (full !== 1'b0) begin
      errors++;
      $display("FAIL mask_full_cleared: got %b expected 0", full);
    end
    for (int c = 1; c <= 6; c++) begin
      wr_t e;
      adc_data = pat(c + 100);
      e.addr = AW'(c - 1);
      e.data = '0;
      e.data[0 +: DW] = adc_data[0 +: DW];
      sb_q.push_back(e);
      tick();
    end
    adc_data = pat(200);
    do_abort("mask");
    sb_empty("mask");
  endtask

  task automatic test_arm_abort_reset();
    log_ratio = 0; chan_mask = '1; mode = 1'b0; pretrig = 0;
    arm = 1'b1; abort = 1'b1;
    tick();
    arm = 1'b0; abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (state !== 3'd0 || wr_en !== 1'b0) begin
        errors++;
        $display("FAIL arm_abort: step %0d got state=%0d wr_en=%b expected 0 0", i, state, wr_en);
      end
      tick();
    end

    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      adc_data = pat(c + 200);
      trig = (c == 2);
      sb_q.push_back('{addr: AW'(c - 1), data: pat(c + 200)});
      tick();
      trig = 1'b0;
    end
    checks++;
    if (state !== 3'd3) begin
      errors++;
      $display("FAIL mid_post: got state=%0d expected 3", state);
    end
    #5;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({state, wr_en, wr_addr, wr_data, trig_ptr, full, done} !== '0) begin
      errors++;
      $display("FAIL async_reset: got state=%0d wr_en=%b wr_addr=%0d trig_ptr=%0d full=%b done=%b expected all 0",
               state, wr_en, wr_addr, trig_ptr, full, done);
    end
    sb_empty("async_reset");
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (state !== 3'd0 || wr_en !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle: got state=%0d wr_en=%b expected 0 0", state, wr_en);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    adc_data  = '0;
    log_ratio = '0;
    chan_mask = '0;
    mode      = 1'b0;
    pretrig   = '0;
    arm       = 1'b0;
    trig      = 1'b0;
    abort     = 1'b0;

    test_reset();
    test_basic();
    test_decimation();
    test_trig_in_pre();
    test_continuous();
    test_mask();
    test_arm_abort_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_capture_seq.md
ADC_CAPTURE_SEQ -- requirements
Module: adc_capture_seq

Interface
REQ-001 SHALL have parameter NCH, default 8, number of ADC channels.
REQ-002 SHALL have parameter DW, default 16, signed sample width per channel.
REQ-003 SHALL have parameter AW, default 14, capture address width (depth 2^AW per channel).
REQ-004 SHALL have parameter LRW, default 4, width of log2 decimation ratio.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port adc_data  input  NCH*DW  channel k at bits [(k+1)*DW-1 -: DW], one sample per clk.
REQ-008 SHALL have port log_ratio  input  LRW  decimation exponent, legal 0..10.
REQ-009 SHALL have port chan_mask  input  NCH  1 = channel enabled.
REQ-010 SHALL have port mode  input  1  0 one-shot, 1 continuous re-arm.
REQ-011 SHALL have port pretrig  input  AW  number of pre-trigger samples.
REQ-012 SHALL have ports arm, trig, abort  input  1 each  single-cycle strobes.
REQ-013 SHALL have ports wr_en  output  1, wr_addr  output  AW, wr_data  output  NCH*DW  memory write port.
REQ-014 SHALL have ports state  output  3, trig_ptr  output  AW, full  output  1, done  output  1.

Function
REQ-015 Decimator SHALL keep per-channel signed accumulator of DW+10 bits; after 2^log_ratio inputs it SHALL emit sum >>> log_ratio (arithmetic, truncating) and a one-cycle strobe.
REQ-016 log_ratio=0 SHALL pass every sample: input at cycle n appears on wr_data with wr_en at cycle n+1.
REQ-017 log_ratio, chan_mask, mode and pretrig SHALL be latched on accepted arm and held constant for the capture.
REQ-018 Decimator phase and accumulators SHALL clear on accepted arm; the first output uses the 2^log_ratio samples starting the cycle after arm.
REQ-019 Masked-off channels SHALL write zero in their wr_data lane.
REQ-020 States: IDLE=0, PRE=1, WAIT=2, POST=3, DONE=4.
REQ-021 IDLE: arm -> PRE, wr_addr cleared to 0, full cleared; when pretrig=0, arm -> WAIT directly.
REQ-022 In PRE, WAIT and POST each decimator strobe SHALL produce wr_en=1; wr_addr advances by 1 after each write, wrapping 2^AW-1 -> 0.
REQ-023 PRE -> WAIT after exactly pretrig writes; trig in PRE SHALL be ignored (not queued).
REQ-024 WAIT: trig -> POST; trigger sample = first write in the cycle of trig or later; trig_ptr = its address.
REQ-025 POST SHALL perform 2^AW - pretrig writes including the trigger sample, then enter DONE with full=1 and done pulsed for one cycle.
REQ-026 DONE, mode=0: remain until arm (-> PRE/WAIT as REQ-021) or abort (-> IDLE); no writes.
REQ-027 DONE, mode=1: after one cycle SHALL re-arm as if arm were asserted, keeping full=1 until the next arm from IDLE.
REQ-028 abort SHALL force IDLE next cycle from any state, suppress wr_en in that cycle, and leave trig_ptr unchanged.
REQ-029 abort SHALL take priority over simultaneous arm or trig; arm outside IDLE/DONE SHALL be ignored.

Reset
REQ-030 rst_n low SHALL immediately set state=IDLE, wr_en=0, wr_addr=0, wr_data=0, trig_ptr=0, full=0, done=0, accumulators=0.
REQ-031 Reset release SHALL leave the block in IDLE with no write until arm.

Verification
REQ-032 AW=4, pretrig=4, log_ratio=0, mode=0: arm, trig 10 cycles later -> 4 PRE writes at addr 0..3, WAIT writes continue, trig_ptr = address of trigger write, exactly 12 POST writes, done one pulse, state=4.
REQ-033 log_ratio=2, ch0 inputs 4,8,12,16 repeating -> wr_en every 4th cycle, ch0 lane = 10; inputs -1,-2 with log_ratio=1 -> -2.
REQ-034 trig pulsed during PRE, none afterwards -> state stays WAIT, no POST writes.
REQ-035 mode=1, AW=4, pretrig=0 -> after DONE, PRE/WAIT re-entered next cycle, wr_addr=0, full stays 1, second trig yields second done pulse.
REQ-036 arm and abort same cycle -> state stays IDLE, no wr_en; rst_n low mid-POST -> all outputs 0 asynchronously.
REQ-037 chan_mask=8'b0000_0001 with nonzero inputs on all channels -> lanes 1..7 write 0.
